cdc_handshake_source: RTL and testbench
=======================================

CDC_HANDSHAKE_SOURCE -- requirements
Module: cdc_handshake_source

Interface
REQ-001 SHALL have parameter W, default 2: payload width in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, legal range 2..4: flop depth of the ack synchronizer.
REQ-003 SHALL have parameter TIMEOUT, default 255, legal range 1..65535: ack-wait cycle limit.
REQ-004 SHALL have port clock, input, 1: the single clock; all flops use its rising edge.
REQ-005 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-006 SHALL have port enq_valid, input, 1: the local producer offers enq_data.
REQ-007 SHALL have port enq_ready, output, 1: the block accepts a payload this cycle.
REQ-008 SHALL have port enq_data, input, W: payload to send.
REQ-009 SHALL have port tx_data, output, W: registered payload, stable for the whole handshake.
REQ-010 SHALL have port tx_req, output, 1: registered request toggle line to the sink.
REQ-011 SHALL have port tx_ack, input, 1: ack toggle from the sink domain, asynchronous to clock.
REQ-012 SHALL have port busy, output, 1: a handshake is in flight.
REQ-013 SHALL have port timeout_err, output, 1: sticky flag, set when an ack wait exceeds TIMEOUT.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, SETTLE, WAIT_ACK.
REQ-015 enq_ready SHALL be 1 only in IDLE; a transfer occurs when enq_valid and enq_ready are both 1.
REQ-016 On a transfer in cycle N: tx_data SHALL take enq_data at edge N+1, and the FSM SHALL enter SETTLE.
REQ-017 SETTLE SHALL last exactly one cycle; tx_req SHALL invert at edge N+2, and the FSM SHALL enter WAIT_ACK, so data is stable one full cycle before the req edge.
REQ-018 tx_ack SHALL pass through a SYNC_STAGES-deep flop chain; ack_s is the chain's last stage.
REQ-019 In WAIT_ACK, when ack_s equals tx_req, the FSM SHALL return to IDLE on the next edge; enq_ready is 1 in the following cycle.
REQ-020 tx_data and tx_req SHALL change only as stated in REQ-016 and REQ-017, and SHALL otherwise hold.
REQ-021 busy SHALL equal 1 in SETTLE and WAIT_ACK, and 0 in IDLE.
REQ-022 A wait counter SHALL clear on entry to WAIT_ACK and increment every WAIT_ACK cycle, saturating at TIMEOUT.
REQ-023 When the wait counter reaches TIMEOUT, timeout_err SHALL set and remain set until reset; the FSM SHALL keep waiting with no abort and no retransmit.
REQ-024 A change of ack_s while in IDLE or SETTLE (spurious ack) SHALL be ignored and SHALL NOT alter state.
REQ-025 enq_valid while not in IDLE SHALL have no effect; enq_data is not sampled.
REQ-026 Minimum round trip in clock cycles SHALL be 2 + SYNC_STAGES + sink latency + 1.

Reset
REQ-027 On reset the block SHALL clear state to IDLE, tx_req to 0, tx_data to 0, all sync flops to 0, the wait counter to 0, and timeout_err to 0.
REQ-028 Reset out of reset: enq_ready SHALL be 1 and busy SHALL be 0 in the first cycle after reset deasserts.
REQ-029 Reset mid-handshake SHALL abandon the transfer with no completion; the system SHALL reset the sink concurrently.

Structure
REQ-030 The FSM state enum and the default W, SYNC_STAGES and TIMEOUT constants SHALL live in shared package cdc_pkg.
REQ-031 The ack synchronizer SHALL be a separate sub-module, cdc_sync_chain, parameterized by width and depth, with no reset-value logic beyond 0.
REQ-032 The sub-module boundary SHALL allow tools to apply CDC constraints to the first sync flop only.

Verification
REQ-033 Reset, then enq_valid=1 with enq_data=2'b10 at cycle 0 -> tx_data=2'b10 at cycle 1; tx_req 0->1 at cycle 2; busy=1 from cycle 1.
REQ-034 Sink model toggles tx_ack 3 cycles after tx_req -> ack_s matches after 2 more cycles; enq_ready=1 exactly 1 cycle later; tx_data unchanged throughout.
REQ-035 Four back-to-back payloads 0,1,2,3 with enq_valid held high -> tx_req toggles 4 times ending at 0; sink captures 0,1,2,3 in order with no loss.
REQ-036 TIMEOUT=5, sink never acks -> timeout_err=1 after 5 WAIT_ACK cycles, busy stays 1; a late ack then returns to IDLE with timeout_err still 1.
REQ-037 Toggle tx_ack while IDLE -> no state change and enq_ready stays 1; reset asserted in WAIT_ACK -> next cycle tx_req=0, busy=0, timeout_err=0.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared definitions for the CDC request/ack handshake source.
//   - cdc_state_e : handshake FSM states
//   - CDC_*       : default payload width, ack synchronizer depth, ack-wait limit
//   - cnt_width() : bits needed to hold 0..max_val
package cdc_pkg;

  localparam int CDC_W           = 2;
  localparam int CDC_SYNC_STAGES = 2;
  localparam int CDC_TIMEOUT     = 255;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_WAIT_ACK = 2'd2
  } cdc_state_e;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cdc_sync_chain.sv
// Multi-flop synchronizer for signals entering the clock domain.
// The first stage (sync_meta) is the only flop that may go metastable, so it
// has its own name for CDC constraints; later stages form sync_pipe.
// Ports:
//   clock : destination clock
//   reset : synchronous active-high, clears every stage to 0
//   d     : asynchronous input
//   q     : synchronized output (last stage)
module cdc_sync_chain #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0]            sync_meta;
  logic [DEPTH-2:0][WIDTH-1:0] sync_pipe;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta <= '0;
      sync_pipe <= '0;
    end else begin
      sync_meta    <= d;
      sync_pipe[0] <= sync_meta;
      for (int i = 1; i < DEPTH - 1; i++) sync_pipe[i] <= sync_pipe[i-1];
    end
  end

  assign q = sync_pipe[DEPTH-2];

endmodule

// File: rtl/cdc_handshake_source.sv
// Source side of a two-phase (toggle) request/ack CDC handshake.
// A payload is captured into tx_data, held one full cycle (SETTLE), then
// tx_req toggles. The sink's ack toggle is synchronized and, once it matches
// tx_req, the block returns to IDLE. A saturating wait counter raises a
// sticky timeout_err if the ack takes TIMEOUT cycles; the wait continues.
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   enq_valid/enq_ready   : producer handshake, transfer when both high
//   enq_data [W]          : payload to send
//   tx_data [W], tx_req   : registered payload and request toggle to sink
//   tx_ack                : ack toggle from sink domain (asynchronous)
//   busy                  : handshake in flight
//   timeout_err           : sticky ack-wait overrun flag
module cdc_handshake_source
  import cdc_pkg::*;
#(
  parameter int W           = CDC_W,
  parameter int SYNC_STAGES = CDC_SYNC_STAGES,
  parameter int TIMEOUT     = CDC_TIMEOUT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enq_valid,
  output logic         enq_ready,
  input  logic [W-1:0] enq_data,
  output logic [W-1:0] tx_data,
  output logic         tx_req,
  input  logic         tx_ack,
  output logic         busy,
  output logic         timeout_err
);

  localparam int            CW      = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  cdc_state_e    state_q, state_d;
  logic          ack_s;
  logic          ack_match;
  logic [CW-1:0] wait_cnt;

  cdc_sync_chain #(
    .WIDTH (1),
    .DEPTH (SYNC_STAGES)
  ) u_ack_sync (
    .clock (clock),
    .reset (reset),
    .d     (tx_ack),
    .q     (ack_s)
  );

  // Two-phase protocol: the sink has answered once its ack level equals ours.
  assign ack_match = (ack_s == tx_req);

  always_comb begin
    state_d   = state_q;
    enq_ready = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        enq_ready = 1'b1;
        busy      = 1'b0;
        if (enq_valid) state_d = ST_SETTLE;
      end
      ST_SETTLE:   state_d = ST_WAIT_ACK;
      // ack_s is only consulted here, so stray acks in other states are ignored.
      ST_WAIT_ACK: if (ack_match) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tx_data     <= '0;
      tx_req      <= 1'b0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && enq_valid) tx_data <= enq_data;
      if (state_q == ST_SETTLE) begin
        // Data has been stable a full cycle; now launch the request edge.
        tx_req   <= ~tx_req;
        wait_cnt <= '0;
      end else if (state_q == ST_WAIT_ACK && !ack_match && wait_cnt != CNT_MAX) begin
        wait_cnt <= wait_cnt + CNT_ONE;
        // Flag on the same edge the counter lands on TIMEOUT.
        if (wait_cnt == CNT_MAX - CNT_ONE) timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cdc_handshake_source.sv
// Directed bench for cdc_handshake_source: a default instance driven by a
// sink model (3-cycle ack latency) and a TIMEOUT=5 instance with a manual ack.
module tb_cdc_handshake_source;

  localparam int SINK_LAT = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  // default instance
  logic       enq_valid = 1'b0;
  logic [1:0] enq_data  = '0;
  logic       enq_ready;
  logic [1:0] tx_data;
  logic       tx_req;
  logic       tx_ack;
  logic       busy;
  logic       timeout_err;

  // TIMEOUT=5 instance
  logic       to_valid = 1'b0;
  logic [1:0] to_data  = '0;
  logic       to_ready;
  logic [1:0] to_tx_data;
  logic       to_req;
  logic       to_ack = 1'b0;
  logic       to_busy;
  logic       to_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  cdc_handshake_source u_dut (
    .clock       (clock),
    .reset       (reset),
    .enq_valid   (enq_valid),
    .enq_ready   (enq_ready),
    .enq_data    (enq_data),
    .tx_data     (tx_data),
    .tx_req      (tx_req),
    .tx_ack      (tx_ack),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  cdc_handshake_source #(.W(2), .SYNC_STAGES(2), .TIMEOUT(5)) u_dut_to (
    .clock       (clock),
    .reset       (reset),
    .enq_valid   (to_valid),
    .enq_ready   (to_ready),
    .enq_data    (to_data),
    .tx_data     (to_tx_data),
    .tx_req      (to_req),
    .tx_ack      (to_ack),
    .busy        (to_busy),
    .timeout_err (to_err)
  );

  // Sink model: sees a req toggle, captures tx_data, toggles ack SINK_LAT
  // cycles after the req edge. spur_ack injects stray ack toggles.
  logic       sink_en  = 1'b0;
  logic       sink_ack = 1'b0;
  logic       spur_ack = 1'b0;
  logic       req_seen = 1'b0;
  int         sink_cnt = 0;
  logic [1:0] cap_q[$];

  assign tx_ack = sink_ack ^ spur_ack;

  always @(posedge clock) begin
    if (reset) begin
      sink_ack <= 1'b0;
      req_seen <= 1'b0;
      sink_cnt <= 0;
      cap_q.delete();
    end else if (sink_en) begin
      if (sink_cnt == 1) begin
        sink_ack <= ~sink_ack;
        sink_cnt <= 0;
      end else if (sink_cnt > 1) begin
        sink_cnt <= sink_cnt - 1;
      end else if (tx_req != req_seen) begin
        req_seen <= tx_req;
        cap_q.push_back(tx_data);
        sink_cnt <= SINK_LAT - 1;
      end
    end
  end

  // tx_req toggle counter
  int   tog_cnt = 0;
  logic req_q   = 1'b0;
  always @(posedge clock) begin
    if (reset) begin
      tog_cnt <= 0;
      req_q   <= 1'b0;
    end else begin
      if (tx_req != req_q) tog_cnt <= tog_cnt + 1;
      req_q <= tx_req;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int guard;

    // reset state
    reset = 1'b1;
    tick(3);
    chk("rst_tx_req",  tx_req, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy",    busy, 0);
    chk("rst_err",     to_err, 0);
    reset = 1'b0;
    chk("rst_ready",   enq_ready, 1);
    chk("rst_busy_lo", busy, 0);
    tick();

    // single transfer, sink latency 3; enq_valid stays high while busy
    sink_en   = 1'b1;
    enq_valid = 1'b1;
    enq_data  = 2'b10;               // cycle 0
    tick();                          // cycle 1
    enq_data  = 2'b01;
    chk("t1_data_c1",  tx_data, 2'b10);
    chk("t1_busy_c1",  busy, 1);
    chk("t1_req_c1",   tx_req, 0);
    chk("t1_ready_c1", enq_ready, 0);
    tick();                          // cycle 2
    chk("t1_req_c2",   tx_req, 1);
    chk("t1_busy_c2",  busy, 1);
    tick(2);                         // cycle 4
    chk("t1_ack_c4",   tx_ack, 0);
    tick();                          // cycle 5
    chk("t1_ack_c5",   tx_ack, 1);
    tick(2);                         // cycle 7: ack_s matches, still waiting
    chk("t1_ready_c7", enq_ready, 0);
    chk("t1_busy_c7",  busy, 1);
    chk("t1_data_c7",  tx_data, 2'b10);
    enq_valid = 1'b0;
    tick();                          // cycle 8
    chk("t1_ready_c8", enq_ready, 1);
    chk("t1_busy_c8",  busy, 0);
    chk("t1_data_c8",  tx_data, 2'b10);
    chk("t1_req_c8",   tx_req, 1);
    chk("t1_cap_n",    cap_q.size(), 1);
    chk("t1_cap_0",    cap_q[0], 2'b10);

    // four back-to-back payloads from reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idx   = 0;
    guard = 0;
    while (idx < 4 && guard < 200) begin
      enq_valid = 1'b1;
      enq_data  = idx[1:0];
      if (enq_ready) idx++;
      tick();
      guard++;
    end
    enq_valid = 1'b0;
    chk("t2_sent", idx, 4);
    guard = 0;
    while (!enq_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk("t2_done",  enq_ready, 1);
    chk("t2_togs",  tog_cnt, 4);
    chk("t2_req",   tx_req, 0);
    chk("t2_cap_n", cap_q.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_cap_%0d", i), cap_q[i], i);

    // stray ack toggles while idle
    spur_ack = 1'b1;
    tick(4);
    chk("t3_ready_a", enq_ready, 1);
    chk("t3_busy_a",  busy, 0);
    chk("t3_req_a",   tx_req, 0);
    chk("t3_data_a",  tx_data, 2'd3);
    spur_ack = 1'b0;
    tick(4);
    chk("t3_ready_b", enq_ready, 1);
    chk("t3_busy_b",  busy, 0);

    // TIMEOUT=5 instance: no ack, then a late ack
    to_valid = 1'b1;
    to_data  = 2'b11;                // cycle 0
    tick();                          // cycle 1
    to_valid = 1'b0;
    chk("t4_busy_c1", to_busy, 1);
    chk("t4_data_c1", to_tx_data, 2'b11);
    tick(5);                         // cycle 6: 4 wait cycles done
    chk("t4_req_c6",  to_req, 1);
    chk("t4_err_c6",  to_err, 0);
    tick();                          // cycle 7: 5 wait cycles done
    chk("t4_err_c7",  to_err, 1);
    chk("t4_busy_c7", to_busy, 1);
    tick(10);
    chk("t4_err_hold",   to_err, 1);
    chk("t4_busy_hold",  to_busy, 1);
    chk("t4_ready_hold", to_ready, 0);
    chk("t4_req_hold",   to_req, 1);
    to_ack = 1'b1;
    tick(2);
    chk("t4_busy_late", to_busy, 1);
    tick();
    chk("t4_busy_done",  to_busy, 0);
    chk("t4_ready_done", to_ready, 1);
    chk("t4_err_done",   to_err, 1);

    // reset while the default instance is in WAIT_ACK
    sink_en   = 1'b0;
    enq_valid = 1'b1;
    enq_data  = 2'b01;
    tick();
    enq_valid = 1'b0;
    tick(2);                         // cycle 3
    chk("t5_busy_pre", busy, 1);
    chk("t5_req_pre",  tx_req, 1);
    reset = 1'b1;
    tick();
    chk("t5_req_rst",  tx_req, 0);
    chk("t5_busy_rst", busy, 0);
    chk("t5_data_rst", tx_data, 0);
    chk("t5_err_rst",  to_err, 0);
    reset = 1'b0;
    chk("t5_ready",    enq_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
